// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle controller: opcodes, funct codes, ALU
// control encodings, aluop codes and the state enumeration.
package mc_ctrl_pkg;

    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_FAULT  = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOP = 3'b101;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;
    localparam logic [1:0] AOP_OR    = 2'b11;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU control: maps the controller's aluop and the R-type funct
// field onto the 3-bit ALU function code.
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucont
);

    always_comb begin
        o_alucont = ALU_ADD;
        case (i_aluop)
            AOP_ADD: o_alucont = ALU_ADD;
            AOP_SUB: o_alucont = ALU_SUB;
            AOP_OR:  o_alucont = ALU_OR;
            default: begin
                case (i_funct)
                    FN_ADD:  o_alucont = ALU_ADD;
                    FN_SUB:  o_alucont = ALU_SUB;
                    FN_AND:  o_alucont = ALU_AND;
                    FN_OR:   o_alucont = ALU_OR;
                    FN_SLT:  o_alucont = ALU_SLT;
                    default: o_alucont = ALU_NOP;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller FSM with memory ready handshake, timeout fault and
// illegal-opcode pulse. Define MC_CTRL_BNE_EN to add BNE (opcode 000101).
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               memread,
    output logic               memwrite,
    output logic               iord,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic               pcwritecond_ne,
    output logic [1:0]         pcsrc,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [2:0]         alucont,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               illegal_op,
    output logic               fault,
    output logic [STATE_W-1:0] state_o
);

    state_t          r_state;
    state_t          w_next;
    state_t          w_dec_next;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_legal;
    logic            w_mem_state;
    logic            w_timeout;
    logic            w_branch;
    logic            w_alu_en;
    logic [1:0]      w_aluop;
    logic [2:0]      w_alucont;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout   = (MEM_TIMEOUT > 0) && (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Counter restarts whenever a memory state is (re)entered; saturates while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (w_mem_state && !mem_ready && (w_next == r_state)) begin
            if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

`ifdef MC_CTRL_BNE_EN
    logic r_is_bne;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  r_is_bne <= 1'b0;
        else if (r_state == S_DECODE)  r_is_bne <= (op == OP_BNE);
    end
`endif

    always_comb begin
        w_dec_next = S_FETCH;
        w_legal    = 1'b1;
        case (op)
            OP_RTYPE:        w_dec_next = S_EXEC;
            OP_LB, OP_SB:    w_dec_next = S_MEMADR;
            OP_ADDI, OP_ORI: w_dec_next = S_IEXEC;
            OP_BEQ:          w_dec_next = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
            OP_BNE:          w_dec_next = S_BRANCH;
`endif
            OP_J:            w_dec_next = S_JUMP;
            default:         w_legal    = 1'b0;
        endcase
    end

    // Ready beats timeout when both land on the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (mem_ready) w_next = S_DECODE; else if (w_timeout) w_next = S_FAULT;
            S_DECODE: w_next = w_dec_next;
            S_MEMADR: w_next = (op == OP_SB) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;  else if (w_timeout) w_next = S_FAULT;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;  else if (w_timeout) w_next = S_FAULT;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_IEXEC:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        w_branch   = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        illegal_op = 1'b0;
        fault      = 1'b0;
        w_aluop    = AOP_ADD;
        w_alu_en   = 1'b0;
        case (r_state)
            S_FETCH: begin
                memread  = 1'b1;
                alusrcb  = 2'b01;
                w_alu_en = 1'b1;
                irwrite  = mem_ready;
                pcwrite  = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                w_alu_en   = 1'b1;
                illegal_op = ~w_legal;
            end
            S_MEMADR: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                w_alu_en = 1'b1;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca  = 1'b1;
                w_aluop  = AOP_FUNCT;
                w_alu_en = 1'b1;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_IEXEC: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                w_aluop  = (op == OP_ORI) ? AOP_OR : AOP_ADD;
                w_alu_en = 1'b1;
            end
            S_IWB:    regwrite = 1'b1;
            S_BRANCH: begin
                alusrca  = 1'b1;
                w_aluop  = AOP_SUB;
                w_alu_en = 1'b1;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            S_FAULT:  fault = 1'b1;
            default:  ;
        endcase
    end

`ifdef MC_CTRL_BNE_EN
    assign pcwritecond    = w_branch & ~r_is_bne;
    assign pcwritecond_ne = w_branch &  r_is_bne;
`else
    assign pcwritecond    = w_branch;
    assign pcwritecond_ne = 1'b0;
`endif

    mc_alu_decode u_alu_decode (
        .i_aluop   (w_aluop),
        .i_funct   (funct),
        .o_alucont (w_alucont)
    );

    // ALU control reads as zero in states that do not use the ALU.
    assign alucont = w_alu_en ? w_alucont : 3'b000;
    assign state_o = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller with an instruction-plan reference model
// and directed literal checks; honours MC_CTRL_BNE_EN.
`timescale 1ns/1ps
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 4;
    localparam int TO_W        = 5;
    localparam int STATE_W     = 4;

    localparam logic [5:0] B_RTYPE = 6'b000000, B_LB = 6'b100000, B_SB = 6'b101000,
                           B_ADDI = 6'b001000, B_ORI = 6'b001101, B_BEQ = 6'b000100,
                           B_BNE = 6'b000101, B_J = 6'b000010, B_BAD = 6'b111111;

    logic clk = 1'b0;
    logic reset_n, mem_ready;
    logic [5:0] op, funct;
    logic memread, memwrite, iord, irwrite, pcwrite, pcwritecond, pcwritecond_ne;
    logic alusrca, regdst, memtoreg, regwrite, illegal_op, fault;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] alucont;
    logic [STATE_W-1:0] state_o;

    int checks = 0;
    int errors = 0;

    state_t m_phase = S_IDLE;
    state_t m_plan[$];
    int     m_wait = 0;
    logic [5:0] m_op = '0;

    always #5 clk = ~clk;

    mc_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W), .STATE_W(STATE_W)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .mem_ready(mem_ready),
        .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .pcwritecond_ne(pcwritecond_ne),
        .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .alucont(alucont),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .illegal_op(illegal_op), .fault(fault), .state_o(state_o)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit op_legal(input logic [5:0] o);
        case (o)
            B_RTYPE, B_LB, B_SB, B_ADDI, B_ORI, B_BEQ, B_J: return 1'b1;
`ifdef MC_CTRL_BNE_EN
            B_BNE: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b101;
        endcase
    endfunction

    // Reference model: check the current cycle, then step to the next phase.
    always @(negedge clk) begin : cmp
        logic e_mr, e_mw, e_iord, e_irw, e_pcw, e_pcc, e_pcne, e_asa, e_rd, e_m2r, e_rw, e_ill, e_flt;
        logic [1:0] e_pcsrc, e_asb;
        logic [2:0] e_alu;
        bit alu_care;
        state_t prev;
        {e_mr, e_mw, e_iord, e_irw, e_pcw, e_pcc, e_pcne, e_asa, e_rd, e_m2r, e_rw, e_ill, e_flt} = '0;
        e_pcsrc = 2'b00; e_asb = 2'b00; e_alu = 3'b000; alu_care = 1'b0;
        if (!reset_n) begin
            m_phase = S_IDLE; m_plan.delete(); m_wait = 0;
            alu_care = 1'b1;
        end else begin
            case (m_phase)
                S_FETCH:  begin e_mr = 1; e_asb = 2'b01; e_alu = 3'b010; alu_care = 1;
                                e_irw = mem_ready; e_pcw = mem_ready; end
                S_DECODE: begin e_asb = 2'b11; e_alu = 3'b010; alu_care = 1; e_ill = !op_legal(op); end
                S_MEMADR: begin e_asa = 1; e_asb = 2'b10; e_alu = 3'b010; alu_care = 1; end
                S_MEMRD:  begin e_mr = 1; e_iord = 1; end
                S_MEMWB:  begin e_rw = 1; e_m2r = 1; end
                S_MEMWR:  begin e_mw = 1; e_iord = 1; end
                S_EXEC:   begin e_asa = 1; e_alu = funct_alu(funct); alu_care = 1; end
                S_ALUWB:  begin e_rd = 1; e_rw = 1; end
                S_IEXEC:  begin e_asa = 1; e_asb = 2'b10; alu_care = 1;
                                e_alu = (m_op == B_ORI) ? 3'b001 : 3'b010; end
                S_IWB:    e_rw = 1;
                S_BRANCH: begin e_asa = 1; e_alu = 3'b110; alu_care = 1; e_pcsrc = 2'b01;
                                if (m_op == B_BNE) e_pcne = 1; else e_pcc = 1; end
                S_JUMP:   begin e_pcw = 1; e_pcsrc = 2'b10; end
                S_FAULT:  e_flt = 1;
                default:  ;
            endcase
        end
        chk("state_o", 8'(state_o), 8'(m_phase));
        chk("memread", 8'(memread), 8'(e_mr));
        chk("memwrite", 8'(memwrite), 8'(e_mw));
        chk("iord", 8'(iord), 8'(e_iord));
        chk("irwrite", 8'(irwrite), 8'(e_irw));
        chk("pcwrite", 8'(pcwrite), 8'(e_pcw));
        chk("pcwritecond", 8'(pcwritecond), 8'(e_pcc));
        chk("pcwritecond_ne", 8'(pcwritecond_ne), 8'(e_pcne));
        chk("pcsrc", 8'(pcsrc), 8'(e_pcsrc));
        chk("alusrca", 8'(alusrca), 8'(e_asa));
        chk("alusrcb", 8'(alusrcb), 8'(e_asb));
        chk("regdst", 8'(regdst), 8'(e_rd));
        chk("memtoreg", 8'(memtoreg), 8'(e_m2r));
        chk("regwrite", 8'(regwrite), 8'(e_rw));
        chk("illegal_op", 8'(illegal_op), 8'(e_ill));
        chk("fault", 8'(fault), 8'(e_flt));
        if (alu_care) chk("alucont", 8'(alucont), 8'(e_alu));

        if (reset_n) begin
            prev = m_phase;
            case (m_phase)
                S_IDLE: m_phase = S_FETCH;
                S_FETCH, S_MEMRD, S_MEMWR: begin
                    if (mem_ready) begin
                        if (m_phase == S_FETCH) m_phase = S_DECODE;
                        else if (m_plan.size() != 0) m_phase = m_plan.pop_front();
                        else m_phase = S_FETCH;
                    end else if (MEM_TIMEOUT > 0 && m_wait == MEM_TIMEOUT - 1) begin
                        m_phase = S_FAULT;
                    end else begin
                        m_wait++;
                    end
                end
                S_DECODE: begin
                    m_op = op;
                    m_plan.delete();
                    case (op)
                        B_RTYPE:      m_plan = '{S_EXEC, S_ALUWB};
                        B_LB:         m_plan = '{S_MEMADR, S_MEMRD, S_MEMWB};
                        B_SB:         m_plan = '{S_MEMADR, S_MEMWR};
                        B_ADDI, B_ORI: m_plan = '{S_IEXEC, S_IWB};
                        B_BEQ:        m_plan.push_back(S_BRANCH);
`ifdef MC_CTRL_BNE_EN
                        B_BNE:        m_plan.push_back(S_BRANCH);
`endif
                        B_J:          m_plan.push_back(S_JUMP);
                        default:      ;
                    endcase
                    m_phase = (m_plan.size() != 0) ? m_plan.pop_front() : S_FETCH;
                end
                S_FAULT: m_phase = S_FAULT;
                default: m_phase = (m_plan.size() != 0) ? m_plan.pop_front() : S_FETCH;
            endcase
            if (m_phase != prev) m_wait = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [5:0] ops[10];
        logic [5:0] fns[6];
        int fault_cyc;
        ops = '{B_RTYPE, B_LB, B_SB, B_ADDI, B_ORI, B_BEQ, B_BNE, B_J, B_BAD, 6'b010001};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        fault_cyc = 0;
        reset_n = 1'b0; mem_ready = 1'b1; op = B_RTYPE; funct = 6'b101010;
        repeat (3) cyc();
        chk("rst_memread", 8'(memread), 8'h0);
        chk("rst_alucont", 8'(alucont), 8'h0);
        reset_n = 1'b1; #1;
        chk("idle_after_release", 8'(state_o), 8'(S_IDLE));
        cyc();
        chk("fetch_state", 8'(state_o), 8'(S_FETCH));
        chk("fetch_memread", 8'(memread), 8'h1);
        chk("fetch_irwrite", 8'(irwrite), 8'h1);
        chk("fetch_pcwrite", 8'(pcwrite), 8'h1);
        cyc();
        chk("rtype_decode", 8'(state_o), 8'(S_DECODE));
        cyc();
        chk("slt_alucont", 8'(alucont), 8'h7);
        cyc();
        chk("aluwb_regwrite", 8'(regwrite), 8'h1);
        chk("aluwb_regdst", 8'(regdst), 8'h1);
        cyc();
        chk("rtype_latency", 8'(state_o), 8'(S_FETCH));

        op = B_LB;
        repeat (3) cyc();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            chk("lb_wait_memread", 8'(memread), 8'h1);
            chk("lb_wait_iord", 8'(iord), 8'h1);
            cyc();
        end
        chk("memwb_state", 8'(state_o), 8'(S_MEMWB));
        chk("memwb_memtoreg", 8'(memtoreg), 8'h1);
        chk("memwb_regwrite", 8'(regwrite), 8'h1);

        cyc();
        mem_ready = 1'b0; op = B_J;
        repeat (3) cyc();
        chk("timeout_boundary", 8'(state_o), 8'(S_FETCH));
        cyc();
        chk("timeout_fault_state", 8'(state_o), 8'(S_FAULT));
        chk("timeout_fault", 8'(fault), 8'h1);
        repeat (3) cyc();
        chk("fault_sticky", 8'(fault), 8'h1);

        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1; mem_ready = 1'b0; op = B_BAD;
        cyc();
        repeat (3) cyc();
        mem_ready = 1'b1;
        cyc();
        chk("ready_wins_state", 8'(state_o), 8'(S_DECODE));
        chk("ready_wins_fault", 8'(fault), 8'h0);
        chk("illegal_pulse", 8'(illegal_op), 8'h1);
        chk("illegal_no_regwrite", 8'(regwrite), 8'h0);
        chk("illegal_no_memwrite", 8'(memwrite), 8'h0);
        chk("illegal_no_pcwrite", 8'(pcwrite), 8'h0);
        cyc();
        chk("illegal_next_fetch", 8'(state_o), 8'(S_FETCH));
        chk("illegal_one_cycle", 8'(illegal_op), 8'h0);

        op = B_BNE;
        cyc();
`ifdef MC_CTRL_BNE_EN
        chk("bne_legal", 8'(illegal_op), 8'h0);
        cyc();
        chk("bne_branch_state", 8'(state_o), 8'(S_BRANCH));
        chk("bne_pcwritecond_ne", 8'(pcwritecond_ne), 8'h1);
        chk("bne_pcwritecond", 8'(pcwritecond), 8'h0);
`else
        chk("bne_illegal", 8'(illegal_op), 8'h1);
        cyc();
        chk("bne_back_to_fetch", 8'(state_o), 8'(S_FETCH));
`endif

        for (int n = 0; n < 3000; n++) begin
            if (!reset_n) begin
                reset_n = 1'b1;
            end else if (m_phase == S_FAULT) begin
                fault_cyc++;
                if (fault_cyc > 2) begin
                    reset_n = 1'b0;
                    fault_cyc = 0;
                end
            end else if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
            end
            if (m_phase == S_FETCH || m_phase == S_IDLE) begin
                op    = ops[$urandom_range(0, 9)];
                funct = fns[$urandom_range(0, 5)];
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle successor to the single-cycle main decoder. It is an FSM that sequences fetch, decode, execute, memory and writeback over several cycles, and drives the shared-ALU / single-memory datapath. It adds a memory ready-handshake with a timeout fault, ORI support, and illegal-opcode detection. It sits between the instruction register (op/funct inputs) and the multicycle datapath.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for mem_ready in any memory state; 0 = no timeout
TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT
STATE_W, 4, width of the state encoding exported on state_o

Ports:
clk  in  1  clock; all state changes on the rising edge
reset_n  in  1  asynchronous active-low reset
op  in  6  opcode from the IR; valid from DECODE onward
funct  in  6  function field from the IR
mem_ready  in  1  memory completes the current read/write this cycle
memread  out  1  memory read strobe
memwrite  out  1  memory write strobe
iord  out  1  address select: 0 = PC, 1 = ALUOut
irwrite  out  1  load the IR
pcwrite  out  1  unconditional PC write
pcwritecond  out  1  PC write if ALU zero
pcwritecond_ne  out  1  PC write if ALU not zero (BNE)
pcsrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
alusrca  out  1  0 = PC, 1 = rs
alusrcb  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
alucont  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt, 101 nop
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  register writeback source is MDR
regwrite  out  1  register file write
illegal_op  out  1  one-cycle pulse on an undecodable opcode
fault  out  1  sticky memory-timeout fault
state_o  out  STATE_W  current state, for debug

Behaviour:
- Outputs are Moore-decoded from the state, except where noted as gated by mem_ready. Any strobe not listed for a state is 0.
- aluop (internal) to alucont: 00 gives add; 01 gives sub; 11 gives or; 10 decodes funct: add, sub, and, or, slt, otherwise nop.
- Reset (reset_n=0): state=IDLE, counter=0, fault=0, all outputs 0. Assertion mid-operation aborts immediately.
- IDLE: all strobes 0; next FETCH. This gives 1 dead cycle after reset release.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - If mem_ready: irwrite=1 and pcwrite=1 in that same cycle, next DECODE.
  - Otherwise stay in FETCH.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - RTYPE 000000 -> EXEC
  - LB 100000 or SB 101000 -> MEMADR
  - ADDI 001000 or ORI 001101 -> IEXEC
  - BEQ 000100 -> BRANCH
  - J 000010 -> JUMP
  - otherwise: illegal_op=1 this cycle, next FETCH
- MEMADR: alusrca=1, alusrcb=10, aluop=00; next MEMRD for LB, MEMWR for SB.
- MEMRD: memread=1, iord=1; on mem_ready go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0; next FETCH.
- MEMWR: memwrite=1, iord=1; on mem_ready go to FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10; next ALUWB.
- ALUWB: regdst=1, regwrite=1; next FETCH.
- IEXEC: alusrca=1, alusrcb=10, aluop=00 for ADDI or 11 for ORI; next IWB.
- IWB: regdst=0, regwrite=1; next FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcwritecond=1; next FETCH.
- JUMP: pcwrite=1, pcsrc=10; next FETCH.
- FAULT: fault=1, all strobes 0; absorbing until reset.
- Timeout counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle spent waiting with mem_ready=0.
  - If MEM_TIMEOUT>0 and the count equals MEM_TIMEOUT-1 with mem_ready=0, go to FAULT.
  - If mem_ready=1 on that same cycle, ready wins and there is no fault.
  - Counter saturates and never wraps.
- Latencies with mem_ready tied 1: R/ADDI/ORI 4 cycles, LB 5, SB 4, BEQ 3, J 3.

Optional Feature:
MC_CTRL_BNE_EN
- Defined: opcode 000101 in DECODE goes to BRANCH, and BRANCH drives pcwritecond_ne=1 instead of pcwritecond. The opcode is held in a 1-bit flag latched in DECODE.
- Undefined: 000101 is treated as an illegal opcode, and pcwritecond_ne is tied to 0.

Decomposition:
- Package mc_ctrl_pkg: opcode constants, funct constants, alucont encodings, aluop codes, and the state enumeration with its STATE_W encoding.
- One sub-module, mc_alu_decode: combinational aluop/funct to alucont.

Test Plan:
- Reset held, then released, mem_ready=1 -> IDLE one cycle, then FETCH with memread=1, irwrite=1, pcwrite=1 in the same cycle; all outputs 0 during reset.
- op=000000, funct=101010, mem_ready=1 -> states FETCH, DECODE, EXEC (alucont=111), ALUWB (regwrite=1, regdst=1), back to FETCH: 4 cycles.
- LB with mem_ready low for 3 cycles in MEMRD -> memread and iord held high for 4 cycles, then MEMWB with memtoreg=1 and regwrite=1.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT entered after 4 cycles, fault=1 and stays 1; a second run with mem_ready=1 on the 4th cycle -> DECODE, no fault.
- op=111111 -> illegal_op pulses for 1 cycle in DECODE, next state FETCH, no regwrite/memwrite/pcwrite.
- op=000101: with MC_CTRL_BNE_EN -> BRANCH asserts pcwritecond_ne=1 and pcwritecond=0; without it -> illegal_op=1.
